// File: rtl/hk_sram_reader_pkg.sv
// Shared housekeeping SRAM reader types and constants.
// Imported by hk_sram_word_fifo and hk_sram_reader.
package hk_sram_reader_pkg;

  localparam int HK_SRAM_AW  = 8;
  localparam int HK_SRAM_DW  = 32;
  localparam int HK_SRAM_LAT = 1;
  localparam int HK_LEN_W    = 9;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } hk_state_t;

  // A zero length request means a full 256-word sweep.
  function automatic logic [HK_LEN_W-1:0] hk_len_eff(
    input logic [HK_LEN_W-1:0] len
  );
    return (len == '0) ? HK_LEN_W'(256) : len;
  endfunction

endpackage

// File: rtl/hk_sram_word_fifo.sv
// Word buffer between the SRAM read port and the byte unpacker.
// Synchronous FIFO with flush; count drives issue throttling.
module hk_sram_word_fifo
  import hk_sram_reader_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    push,
  input  logic [HK_SRAM_DW-1:0]   push_data,
  input  logic                    pop,
  output logic [HK_SRAM_DW-1:0]   head,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [HK_SRAM_DW-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  full;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; flush empties the buffer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage array; contents are only observed behind count.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/hk_sram_reader.sv
// Housekeeping burst reader: SRAM read port to byte stream.
// Option: HK_SRAM_READER_MSB_FIRST_EN reverses byte order per word.
module hk_sram_reader
  import hk_sram_reader_pkg::*;
#(
  parameter int FIFO_WORDS = 2,
  parameter int SRAM_LAT   = HK_SRAM_LAT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [HK_SRAM_AW-1:0] req_addr,
  input  logic [HK_LEN_W-1:0]   req_len,
  input  logic                  abort,
  output logic                  hkspi_sram_clk,
  output logic                  hkspi_sram_csb,
  output logic [HK_SRAM_AW-1:0] hkspi_sram_addr,
  input  logic [HK_SRAM_DW-1:0] hkspi_sram_rdata,
  output logic                  byte_valid,
  input  logic                  byte_ready,
  output logic [7:0]            byte_data,
  output logic                  busy
);

  localparam int CW = $clog2(FIFO_WORDS) + 1;

  hk_state_t             state;
  hk_state_t             state_n;
  logic                  csb_n;
  logic [HK_SRAM_AW-1:0] addr_n;
  logic [HK_SRAM_AW-1:0] ptr;
  logic [HK_SRAM_AW-1:0] ptr_n;
  logic [HK_LEN_W-1:0]   rem;
  logic [HK_LEN_W-1:0]   rem_n;
  logic [SRAM_LAT-1:0]   tag;
  logic [1:0]            bidx;
  logic [1:0]            sel;
  logic                  flush;
  logic                  push;
  logic                  pop;
  logic                  xfer;
  logic                  fifo_empty;
  logic [HK_SRAM_DW-1:0] head;
  logic [CW-1:0]         count;
  logic [31:0]           free_w;
  logic [31:0]           infl_w;
  logic                  room;
  logic                  idle_ok;

  assign hkspi_sram_clk = clk;
  assign req_ready      = (state == ST_IDLE);
  assign flush          = abort;
  assign push           = tag[SRAM_LAT-1];
  assign byte_valid     = !fifo_empty;
  assign xfer           = byte_valid && byte_ready;
  assign pop            = xfer && (bidx == 2'd3);
  assign busy           = (state != ST_IDLE) || byte_valid;

  hk_sram_word_fifo #(
    .DEPTH (FIFO_WORDS)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (push),
    .push_data (hkspi_sram_rdata),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .empty     (fifo_empty)
  );

  // Reads in flight versus free slots; decides next-cycle issue.
  always_comb begin
    infl_w = 32'(!hkspi_sram_csb);
    for (int i = 0; i < SRAM_LAT; i++) begin
      infl_w = infl_w + 32'(tag[i]);
    end
    free_w  = 32'(FIFO_WORDS) - 32'(count);
    room    = free_w > infl_w;
    idle_ok = fifo_empty && (infl_w == 32'd0) && (bidx == 2'd0);
  end

  // Next state and next registered SRAM port values.
  always_comb begin
    state_n = state;
    csb_n   = 1'b1;
    addr_n  = hkspi_sram_addr;
    ptr_n   = ptr;
    rem_n   = rem;
    if (abort) begin
      state_n = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (req_valid) begin
            state_n = ST_ISSUE;
            csb_n   = 1'b0;
            addr_n  = req_addr;
            ptr_n   = req_addr + HK_SRAM_AW'(1);
            rem_n   = hk_len_eff(req_len) - HK_LEN_W'(1);
          end
        end
        ST_ISSUE: begin
          if (rem == '0) begin
            state_n = ST_DRAIN;
          end else if (room) begin
            csb_n  = 1'b0;
            addr_n = ptr;
            ptr_n  = ptr + HK_SRAM_AW'(1);
            rem_n  = rem - HK_LEN_W'(1);
          end
        end
        ST_DRAIN: begin
          if (idle_ok) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // State, burst bookkeeping and the registered SRAM port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= ST_IDLE;
      hkspi_sram_csb  <= 1'b1;
      hkspi_sram_addr <= '0;
      ptr             <= '0;
      rem             <= '0;
    end else begin
      state           <= state_n;
      hkspi_sram_csb  <= csb_n;
      hkspi_sram_addr <= addr_n;
      ptr             <= ptr_n;
      rem             <= rem_n;
    end
  end

  // Tag pipeline marks when a read's rdata lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag <= '0;
    end else if (flush) begin
      tag <= '0;
    end else begin
      tag[0] <= !hkspi_sram_csb;
      for (int i = 1; i < SRAM_LAT; i++) begin
        tag[i] <= tag[i-1];
      end
    end
  end

  // Byte index within the head word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bidx <= 2'd0;
    end else if (flush) begin
      bidx <= 2'd0;
    end else if (xfer) begin
      bidx <= bidx + 2'd1;
    end
  end

  // Lane select; output is zero whenever no byte is offered.
  always_comb begin
`ifdef HK_SRAM_READER_MSB_FIRST_EN
    sel = 2'd3 - bidx;
`else
    sel = bidx;
`endif
    byte_data = 8'h00;
    if (byte_valid) byte_data = head[{sel, 3'b000} +: 8];
  end

endmodule

// File: tb/tb_hk_sram_reader.sv
// Directed-random bench for hk_sram_reader.
// Expected stream built from an SRAM array and the burst rules.
module tb_hk_sram_reader;
  import hk_sram_reader_pkg::*;

  localparam int FW = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_addr;
  logic [8:0]  req_len;
  logic        abort;
  logic        sram_clk;
  logic        sram_csb;
  logic [7:0]  sram_addr;
  logic [31:0] sram_rdata = '0;
  logic        byte_valid;
  logic        byte_ready;
  logic [7:0]  byte_data;
  logic        busy;

  logic [31:0] mem [256];
  logic [7:0]  exp_q [$];
  logic [7:0]  expa_q [$];
  int          rd_cycles [$];
  int          byte_cycles [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          issued = 0;
  int          consumed = 0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = '0;
  int          t;

  hk_sram_reader #(.FIFO_WORDS(FW), .SRAM_LAT(1)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_addr         (req_addr),
    .req_len          (req_len),
    .abort            (abort),
    .hkspi_sram_clk   (sram_clk),
    .hkspi_sram_csb   (sram_csb),
    .hkspi_sram_addr  (sram_addr),
    .hkspi_sram_rdata (sram_rdata),
    .byte_valid       (byte_valid),
    .byte_ready       (byte_ready),
    .byte_data        (byte_data),
    .busy             (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!sram_csb) sram_rdata <= mem[sram_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_burst(input int a, input int len);
    int n;
    logic [31:0] w;
    n = (len == 0) ? 256 : len;
    for (int i = 0; i < n; i++) begin
      w = mem[(a + i) % 256];
      expa_q.push_back(8'((a + i) % 256));
      for (int k = 0; k < 4; k++) begin
`ifdef HK_SRAM_READER_MSB_FIRST_EN
        exp_q.push_back(w[8*(3-k) +: 8]);
`else
        exp_q.push_back(w[8*k +: 8]);
`endif
      end
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    expa_q.delete();
    rd_cycles.delete();
    byte_cycles.delete();
    issued = 0;
    consumed = 0;
    prev_stall = 1'b0;
  endtask

  task automatic monitor();
    cyc++;
    if (sram_csb === 1'b0) begin
      issued++;
      rd_cycles.push_back(cyc);
      chk("rd_pending", 32'(expa_q.size() != 0), 1);
      if (expa_q.size() != 0) chk("rd_addr", 32'(sram_addr), 32'(expa_q.pop_front()));
    end
    chk("outstanding", 32'((issued - consumed / 4) <= FW), 1);
    if (prev_stall) begin
      chk("stall_valid", 32'(byte_valid), 1);
      chk("stall_data", 32'(byte_data), 32'(prev_data));
    end
    if (byte_valid && byte_ready) begin
      byte_cycles.push_back(cyc);
      consumed++;
      chk("byte_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("byte_data", 32'(byte_data), 32'(exp_q.pop_front()));
    end
    prev_stall = byte_valid && !byte_ready;
    prev_data = byte_data;
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int a, input int len, output int tt);
    for (int i = 0; i < 50 && !req_ready; i++) cycle();
    chk("req_ready_wait", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_addr = 8'(a);
    req_len = 9'(len);
    load_burst(a, len);
    cycle();
    tt = cyc;
    req_valid = 1'b0;
  endtask

  task automatic drain(input int budget, input bit rnd);
    int i;
    for (i = 0; i < budget; i++) begin
      if (rnd) byte_ready = 1'($urandom_range(0, 1));
      if (!busy && exp_q.size() == 0) break;
      cycle();
    end
    byte_ready = 1'b1;
    chk("drain_timeout", 32'(i < budget), 1);
    chk("drain_bytes_left", 32'(exp_q.size()), 0);
    chk("drain_reads_left", 32'(expa_q.size()), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    reset = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    req_len = '0;
    abort = 1'b0;
    byte_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_csb", 32'(sram_csb), 1);
    chk("rst_addr", 32'(sram_addr), 0);
    chk("rst_byte_valid", 32'(byte_valid), 0);
    chk("rst_byte_data", 32'(byte_data), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    cycle();

    // single word, exact cycle timing
    mem[8'h10] = 32'h44332211;
    clear_model();
    send(8'h10, 1, t);
    drain(100, 1'b0);
    chk("t1_nrd", 32'(rd_cycles.size()), 1);
    if (rd_cycles.size() != 0) chk("t1_rd_cyc", 32'(rd_cycles[0] - t), 1);
    chk("t1_nbytes", 32'(byte_cycles.size()), 4);
    for (int k = 0; k < 4 && k < byte_cycles.size(); k++) begin
      chk("t1_byte_cyc", 32'(byte_cycles[k] - t), 32'(3 + k));
    end
    chk("t1_idle_ready", 32'(req_ready), 1);

    // address wrap at 0xFF
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    clear_model();
    send(8'hFE, 4, t);
    drain(200, 1'b0);
    chk("t2_nrd", 32'(issued), 4);
    chk("t2_nbytes", 32'(consumed), 16);

    // zero length means 256 words, no bubbles
    clear_model();
    send(8'h00, 0, t);
    drain(3000, 1'b0);
    chk("t3_nrd", 32'(issued), 256);
    chk("t3_nbytes", 32'(consumed), 1024);
    if (byte_cycles.size() == 1024) begin
      chk("t3_bubbles", 32'(byte_cycles[1023] - byte_cycles[0]), 1023);
    end

    // random backpressure
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      clear_model();
      send(int'($urandom_range(0, 255)), 8, t);
      drain(2000, 1'b1);
      chk("t4_nbytes", 32'(consumed), 32);
    end

    // abort mid burst, then a fresh burst
    clear_model();
    send(int'($urandom_range(0, 255)), 16, t);
    for (int i = 0; i < 100 && consumed < 5; i++) cycle();
    chk("t5_reach5", 32'(consumed), 5);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_csb", 32'(sram_csb), 1);
    chk("abort_valid", 32'(byte_valid), 0);
    chk("abort_ready", 32'(req_ready), 1);
    clear_model();
    repeat (3) cycle();
    chk("abort_quiet", 32'(issued + consumed), 0);
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    send(int'($urandom_range(0, 255)), 3, t);
    drain(200, 1'b0);
    chk("t5_fresh_bytes", 32'(consumed), 12);

    // abort beats a simultaneous request
    clear_model();
    req_valid = 1'b1;
    req_addr = 8'h20;
    req_len = 9'd2;
    abort = 1'b1;
    cycle();
    req_valid = 1'b0;
    abort = 1'b0;
    chk("abort_req_busy", 32'(busy), 0);
    chk("abort_req_csb", 32'(sram_csb), 1);
    cycle();
    chk("abort_req_noread", 32'(issued), 0);

    // asynchronous reset mid burst
    clear_model();
    send(int'($urandom_range(0, 255)), 4, t);
    repeat (3) cycle();
    #1;
    reset = 1'b1;
    #1;
    chk("arst_csb", 32'(sram_csb), 1);
    chk("arst_valid", 32'(byte_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_ready", 32'(req_ready), 1);
    clear_model();
    cycle();
    reset = 1'b0;
    clear_model();
    cycle();
    send(int'($urandom_range(0, 255)), 2, t);
    drain(200, 1'b0);
    chk("post_rst_bytes", 32'(consumed), 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
